midi_serializer: RTL and testbench

Transmit-side counterpart of the MIDI input parser. Drains the channel-command FIFO (status byte plus up to two 7-bit data bytes per entry) and the system-message FIFO (byte stream with a `last` flag per message). Serialises both into one MIDI byte stream and writes it to the UART TX FIFO. Arbitration happens only at message boundaries, so bytes from the two sources are never interleaved.

---
 rtl/midi_serializer.sv | 217 +++++++++++++++++++++
 tb/tb_midi_serializer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_serializer.sv
// midi_serializer: merges channel commands and system messages into one MIDI byte stream for the UART TX FIFO.
// Define MIDI_RUNNING_STATUS_EN to suppress repeated status bytes (running status).
module midi_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_fifo_valid,
    output logic       cmd_fifo_rd,
    input  logic [7:0] cmd_fifo_head,
    input  logic [6:0] cmd_fifo_data1,
    input  logic [6:0] cmd_fifo_data2,
    input  logic       sysex_fifo_valid,
    output logic       sysex_fifo_rd,
    input  logic [7:0] sysex_fifo_data,
    input  logic       sysex_fifo_last,
    input  logic       uart_fifo_busy,
    output logic       uart_fifo_wr,
    output logic [7:0] uart_fifo_data,
    output logic [7:0] cmd_err_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD_HEAD = 3'd1,
        S_CMD_D1   = 3'd2,
        S_CMD_D2   = 3'd3,
        S_SYSEX    = 3'd4
    } state_t;

    // Number of data bytes carried by a command head; 0 marks an invalid head.
    function automatic logic [1:0] cmd_len(input logic [7:0] head);
        logic [1:0] len;
        case (head[7:4])
            4'hC, 4'hD:                   len = 2'd1;
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
            default:                      len = 2'd0;
        endcase
        return len;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] head_r;
    logic [6:0] data1_r;
    logic [6:0] data2_r;
    logic       last_was_cmd_r;
    logic       last_was_cmd_nxt_s;
    logic [7:0] err_count_r;
    logic [7:0] err_count_nxt_s;
    logic       cmd_pop_s;
    logic       sysex_pop_s;
    logic       wr_s;
    logic [7:0] data_s;
    logic       sel_cmd_s;
    logic       sel_sysex_s;
    logic       rs_match_s;

    // Round-robin only matters when both sources are ready at a message boundary.
    assign sel_cmd_s   = cmd_fifo_valid & (~sysex_fifo_valid | ~last_was_cmd_r);
    assign sel_sysex_s = sysex_fifo_valid & (~cmd_fifo_valid | last_was_cmd_r);

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] rs_r;
    logic [7:0] rs_nxt_s;

    assign rs_match_s = (cmd_fifo_head == rs_r);

    // Running status follows every accepted head; invalid heads and system common bytes drop it.
    always_comb begin
        rs_nxt_s = rs_r;
        if (cmd_fifo_rd) begin
            if (cmd_len(cmd_fifo_head) == 2'd0) begin
                rs_nxt_s = 8'h00;
            end else begin
                rs_nxt_s = cmd_fifo_head;
            end
        end else if (sysex_fifo_rd && (sysex_fifo_data[7:3] == 5'b11110)) begin
            rs_nxt_s = 8'h00;
        end else begin
            rs_nxt_s = rs_r;
        end
    end

    // Running-status register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_r <= 8'h00;
        end else begin
            rs_r <= rs_nxt_s;
        end
    end
`else
    assign rs_match_s = 1'b0;
`endif

    // Next-state and output decode; busy only stalls emission states.
    always_comb begin
        state_nxt_s        = state_r;
        last_was_cmd_nxt_s = last_was_cmd_r;
        err_count_nxt_s    = err_count_r;
        cmd_pop_s          = 1'b0;
        sysex_pop_s        = 1'b0;
        wr_s               = 1'b0;
        data_s             = 8'h00;
        case (state_r)
            S_IDLE: begin
                if (sel_cmd_s) begin
                    cmd_pop_s = 1'b1;
                    if (cmd_len(cmd_fifo_head) == 2'd0) begin
                        if (err_count_r != 8'hFF) begin
                            err_count_nxt_s = err_count_r + 8'd1;
                        end else begin
                            err_count_nxt_s = err_count_r;
                        end
                        state_nxt_s = S_IDLE;
                    end else if (rs_match_s) begin
                        state_nxt_s = S_CMD_D1;
                    end else begin
                        state_nxt_s = S_CMD_HEAD;
                    end
                end else if (sel_sysex_s) begin
                    state_nxt_s = S_SYSEX;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CMD_HEAD: begin
                if (!uart_fifo_busy) begin
                    wr_s        = 1'b1;
                    data_s      = head_r;
                    state_nxt_s = S_CMD_D1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_CMD_D1: begin
                if (!uart_fifo_busy) begin
                    wr_s   = 1'b1;
                    data_s = {1'b0, data1_r};
                    if (cmd_len(head_r) == 2'd2) begin
                        state_nxt_s = S_CMD_D2;
                    end else begin
                        state_nxt_s        = S_IDLE;
                        last_was_cmd_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_CMD_D2: begin
                if (!uart_fifo_busy) begin
                    wr_s               = 1'b1;
                    data_s             = {1'b0, data2_r};
                    state_nxt_s        = S_IDLE;
                    last_was_cmd_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_SYSEX: begin
                if (sysex_fifo_valid && !uart_fifo_busy) begin
                    sysex_pop_s = 1'b1;
                    wr_s        = 1'b1;
                    data_s      = sysex_fifo_data;
                    if (sysex_fifo_last) begin
                        state_nxt_s        = S_IDLE;
                        last_was_cmd_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, arbitration history and error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            last_was_cmd_r <= 1'b0;
            err_count_r    <= 8'h00;
        end else begin
            state_r        <= state_nxt_s;
            last_was_cmd_r <= last_was_cmd_nxt_s;
            err_count_r    <= err_count_nxt_s;
        end
    end

    // Command fields are captured on the pop since the FIFO head moves on afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= 8'h00;
            data1_r <= 7'h00;
            data2_r <= 7'h00;
        end else if (cmd_pop_s) begin
            head_r  <= cmd_fifo_head;
            data1_r <= cmd_fifo_data1;
            data2_r <= cmd_fifo_data2;
        end else begin
            head_r  <= head_r;
            data1_r <= data1_r;
            data2_r <= data2_r;
        end
    end

    // No pop may escape while reset holds the FSM in idle.
    assign cmd_fifo_rd    = cmd_pop_s & ~rst;
    assign sysex_fifo_rd  = sysex_pop_s;
    assign uart_fifo_wr   = wr_s;
    assign uart_fifo_data = data_s;
    assign cmd_err_count  = err_count_r;

endmodule

// File: tb/tb_midi_serializer.sv
// tb_midi_serializer: queue-backed FIFOs feed the serializer; a message-level model predicts the byte stream.
module tb_midi_serializer;

    typedef struct {
        logic [7:0] head;
        logic [6:0] d1;
        logic [6:0] d2;
    } cmd_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } sys_t;

`ifdef MIDI_RUNNING_STATUS_EN
    localparam bit RS_EN = 1'b1;
`else
    localparam bit RS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_fifo_valid;
    logic       cmd_fifo_rd;
    logic [7:0] cmd_fifo_head;
    logic [6:0] cmd_fifo_data1;
    logic [6:0] cmd_fifo_data2;
    logic       sysex_fifo_valid;
    logic       sysex_fifo_rd;
    logic [7:0] sysex_fifo_data;
    logic       sysex_fifo_last;
    logic       uart_fifo_busy;
    logic       uart_fifo_wr;
    logic [7:0] uart_fifo_data;
    logic [7:0] cmd_err_count;

    midi_serializer dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_fifo_valid   (cmd_fifo_valid),
        .cmd_fifo_rd      (cmd_fifo_rd),
        .cmd_fifo_head    (cmd_fifo_head),
        .cmd_fifo_data1   (cmd_fifo_data1),
        .cmd_fifo_data2   (cmd_fifo_data2),
        .sysex_fifo_valid (sysex_fifo_valid),
        .sysex_fifo_rd    (sysex_fifo_rd),
        .sysex_fifo_data  (sysex_fifo_data),
        .sysex_fifo_last  (sysex_fifo_last),
        .uart_fifo_busy   (uart_fifo_busy),
        .uart_fifo_wr     (uart_fifo_wr),
        .uart_fifo_data   (uart_fifo_data),
        .cmd_err_count    (cmd_err_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    cmd_t       cmd_q[$];
    sys_t       sys_q[$];
    logic [7:0] exp_q[$];
    int         rd_log[$];
    int         wr_log[$];
    int         cyc = 0;
    int         busy_lo = 0;
    int         busy_hi = 0;
    int         busy_pct = 0;
    int         gap_pct = 0;
    bit         sys_mid = 1'b0;
    bit         m_last_cmd = 1'b0;
    int         m_err = 0;
    logic [7:0] m_rs = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int data_bytes(input logic [7:0] head);
        int hi;
        hi = int'(head[7:4]);
        if (hi == 12 || hi == 13) return 1;
        if (hi >= 8 && hi != 15) return 2;
        return 0;
    endfunction

    // Message-level model: decides source order at each boundary and expands messages into bytes.
    task automatic build_expected();
        int ci = 0;
        int si = 0;
        bit take_cmd;
        bit done;
        int n;
        while (ci < cmd_q.size() || si < sys_q.size()) begin
            if (ci < cmd_q.size() && si < sys_q.size()) take_cmd = !m_last_cmd;
            else take_cmd = (ci < cmd_q.size());
            if (take_cmd) begin
                n = data_bytes(cmd_q[ci].head);
                if (n == 0) begin
                    if (m_err < 255) m_err++;
                    m_rs = 8'h00;
                end else begin
                    if (!(RS_EN && cmd_q[ci].head == m_rs)) exp_q.push_back(cmd_q[ci].head);
                    m_rs = cmd_q[ci].head;
                    exp_q.push_back({1'b0, cmd_q[ci].d1});
                    if (n == 2) exp_q.push_back({1'b0, cmd_q[ci].d2});
                    m_last_cmd = 1'b1;
                end
                ci++;
            end else begin
                done = 1'b0;
                while (!done) begin
                    exp_q.push_back(sys_q[si].data);
                    if (RS_EN && sys_q[si].data >= 8'hF0 && sys_q[si].data <= 8'hF7) m_rs = 8'h00;
                    done = sys_q[si].last;
                    si++;
                end
                m_last_cmd = 1'b0;
            end
        end
    endtask

    task automatic drive();
        uart_fifo_busy = ((cyc >= busy_lo) && (cyc < busy_hi)) || (int'($urandom_range(99)) < busy_pct);
        cmd_fifo_valid = (cmd_q.size() > 0);
        cmd_fifo_head  = (cmd_q.size() > 0) ? cmd_q[0].head : 8'h00;
        cmd_fifo_data1 = (cmd_q.size() > 0) ? cmd_q[0].d1 : 7'h00;
        cmd_fifo_data2 = (cmd_q.size() > 0) ? cmd_q[0].d2 : 7'h00;
        sysex_fifo_valid = (sys_q.size() > 0) && !(sys_mid && (int'($urandom_range(99)) < gap_pct));
        sysex_fifo_data  = (sys_q.size() > 0) ? sys_q[0].data : 8'h00;
        sysex_fifo_last  = (sys_q.size() > 0) ? sys_q[0].last : 1'b0;
    endtask

    task automatic step();
        logic pop_c;
        logic pop_s;
        @(negedge clk);
        pop_c = cmd_fifo_rd;
        pop_s = sysex_fifo_rd;
        check_val("wr_while_busy", 32'(uart_fifo_wr & uart_fifo_busy), 32'd0);
        if (uart_fifo_wr) begin
            wr_log.push_back(cyc);
            if (exp_q.size() > 0) check_val("byte", 32'(uart_fifo_data), 32'(exp_q.pop_front()));
            else check_val("unexpected_wr", 32'(uart_fifo_data), 32'hFFFF_FFFF);
        end else begin
            check_val("idle_data", 32'(uart_fifo_data), 32'd0);
        end
        if (pop_c) begin
            rd_log.push_back(cyc);
            check_val("cmd_rd_empty", 32'(cmd_fifo_valid), 32'd1);
        end
        if (pop_s) check_val("sys_rd_empty", 32'(sysex_fifo_valid), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
        if (pop_c && cmd_q.size() > 0) cmd_q.delete(0);
        if (pop_s && sys_q.size() > 0) begin
            sys_mid = !sys_q[0].last;
            sys_q.delete(0);
        end
        drive();
    endtask

    task automatic run_scenario();
        cyc = 0;
        rd_log.delete();
        wr_log.delete();
        build_expected();
        drive();
        while ((cmd_q.size() > 0 || sys_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) step();
        check_val("drain_timeout", 32'(cmd_q.size() + sys_q.size() + exp_q.size()), 32'd0);
        exp_q.delete();
        busy_lo = 0;
        busy_hi = 0;
        for (int i = 0; i < 4; i++) step();
        check_val("err_count", 32'(cmd_err_count), 32'(m_err));
    endtask

    task automatic push_cmd(input logic [7:0] h, input logic [6:0] a, input logic [6:0] b);
        cmd_t c;
        c.head = h;
        c.d1   = a;
        c.d2   = b;
        cmd_q.push_back(c);
    endtask

    task automatic push_sys(input logic [7:0] d, input logic l);
        sys_t s;
        s.data = d;
        s.last = l;
        sys_q.push_back(s);
    endtask

    function automatic logic [7:0] rand_head();
        logic [7:0] h;
        int r;
        r = int'($urandom_range(9));
        if (r == 0) begin
            h = 8'($urandom);
            h[7] = 1'b0;
        end else if (r == 1) begin
            h = {4'hF, 4'($urandom)};
        end else begin
            case ($urandom_range(6))
                0:       h = 8'h80;
                1:       h = 8'h90;
                2:       h = 8'hA0;
                3:       h = 8'hB0;
                4:       h = 8'hC0;
                5:       h = 8'hD0;
                default: h = 8'hE0;
            endcase
            h[0] = 1'($urandom);
        end
        return h;
    endfunction

    initial begin
        rst = 1'b1;
        uart_fifo_busy = 1'b0;
        sysex_fifo_valid = 1'b0;
        sysex_fifo_data = 8'h00;
        sysex_fifo_last = 1'b0;
        cmd_fifo_valid = 1'b1;
        cmd_fifo_head = 8'h90;
        cmd_fifo_data1 = 7'h3C;
        cmd_fifo_data2 = 7'h64;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_cmd_rd", 32'(cmd_fifo_rd), 32'd0);
        check_val("rst_sys_rd", 32'(sysex_fifo_rd), 32'd0);
        check_val("rst_wr", 32'(uart_fifo_wr), 32'd0);
        check_val("rst_data", 32'(uart_fifo_data), 32'd0);
        check_val("rst_err", 32'(cmd_err_count), 32'd0);
        @(posedge clk);
        #1;
        cmd_fifo_valid = 1'b0;
        rst = 1'b0;

        // Single note-on: pop at 0, bytes at 1..3.
        push_cmd(8'h90, 7'h3C, 7'h64);
        run_scenario();
        check_val("lat_rd_pulses", 32'(rd_log.size()), 32'd1);
        check_val("lat_wr_count", 32'(wr_log.size()), 32'd3);
        if (rd_log.size() == 1 && wr_log.size() == 3) begin
            check_val("lat_rd_cycle", 32'(rd_log[0]), 32'd0);
            for (int i = 0; i < 3; i++) check_val("lat_wr_cycle", 32'(wr_log[i]), 32'(i + 1));
        end

        // One-data-byte command: data2 never emitted.
        push_cmd(8'hC5, 7'h12, 7'h7F);
        run_scenario();
        check_val("c5_wr_count", 32'(wr_log.size()), 32'd2);

        // TX busy for three cycles while data1 is pending.
        push_cmd(8'h90, 7'h3C, 7'h64);
        busy_lo = 2;
        busy_hi = 5;
        run_scenario();
        check_val("busy_wr_count", 32'(wr_log.size()), 32'd3);
        if (wr_log.size() == 3) check_val("busy_d1_cycle", 32'(wr_log[1]), 32'd5);

        // Sysex with a command pending, and gaps inside the message.
        push_cmd(8'h80, 7'h40, 7'h00);
        push_sys(8'hF0, 1'b0);
        push_sys(8'h7E, 1'b0);
        push_sys(8'h01, 1'b0);
        push_sys(8'hF7, 1'b1);
        gap_pct = 60;
        run_scenario();
        gap_pct = 0;

        // Two invalid heads.
        push_cmd(8'h3A, 7'h01, 7'h02);
        push_cmd(8'hF8, 7'h03, 7'h04);
        run_scenario();
        check_val("err_two", 32'(cmd_err_count), 32'd2);
        check_val("invalid_no_wr", 32'(wr_log.size()), 32'd0);

        // Same head twice, then with a system message between.
        push_cmd(8'h90, 7'h3C, 7'h64);
        push_cmd(8'h90, 7'h3E, 7'h50);
        run_scenario();
        push_sys(8'hF8, 1'b1);
        run_scenario();
        push_cmd(8'h90, 7'h3C, 7'h64);
        push_cmd(8'h90, 7'h3E, 7'h50);
        push_sys(8'hF6, 1'b1);
        run_scenario();

        // Randomized mixes with random back-pressure and sysex gaps.
        for (int s = 0; s < 25; s++) begin
            int nc;
            int ns;
            int len;
            nc = int'($urandom_range(6));
            ns = int'($urandom_range(4));
            for (int i = 0; i < nc; i++) push_cmd(rand_head(), 7'($urandom), 7'($urandom));
            for (int m = 0; m < ns; m++) begin
                len = int'($urandom_range(1, 4));
                push_sys(8'hF0 + 8'($urandom_range(15)), (len == 1));
                for (int b = 1; b < len; b++) push_sys({1'b0, 7'($urandom)}, (b == len - 1));
            end
            busy_pct = int'($urandom_range(50));
            gap_pct  = int'($urandom_range(60));
            run_scenario();
        end
        busy_pct = 0;
        gap_pct = 0;

        // Reset in the middle of a command: remaining bytes are abandoned.
        push_cmd(8'h90, 7'h3C, 7'h64);
        cyc = 0;
        build_expected();
        drive();
        step();
        step();
        rst = 1'b1;
        exp_q.delete();
        cmd_q.delete();
        sys_q.delete();
        sys_mid = 1'b0;
        drive();
        @(negedge clk);
        check_val("midrst_wr", 32'(uart_fifo_wr), 32'd0);
        check_val("midrst_data", 32'(uart_fifo_data), 32'd0);
        check_val("midrst_err", 32'(cmd_err_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_last_cmd = 1'b0;
        m_err = 0;
        m_rs = 8'h00;
        for (int i = 0; i < 5; i++) step();

        // Error counter saturation.
        for (int i = 0; i < 300; i++) push_cmd({1'b0, 7'($urandom)}, 7'h00, 7'h00);
        run_scenario();
        check_val("err_saturated", 32'(cmd_err_count), 32'd255);
        push_cmd(8'hF3, 7'h00, 7'h00);
        run_scenario();
        check_val("err_stays_255", 32'(cmd_err_count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
